// File: rtl/rr_bus_arbiter_if.sv
// Bus-arbitration handshake bundle: request lines in, grant/owner/status out.
// master = requester side, slave = arbiter side.
interface rr_bus_arbiter_if;
  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  logic [N_REQ-1:0] iReq;
  logic [N_REQ-1:0] oGnt;
  logic [IDX_W-1:0] oGntIdx;
  logic             oBusy;
  logic             oTimeout;

  modport master (output iReq, input oGnt, oGntIdx, oBusy, oTimeout);
  modport slave  (input iReq, output oGnt, oGntIdx, oBusy, oTimeout);
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin owner arbiter for the 16-bit internal bus, 8 requesters, one-cycle turnaround.
// Optional forced-release hold limit (HOLD_MAX) built only when ARB_TIMEOUT_EN is defined.
module rr_bus_arbiter
`ifdef ARB_TIMEOUT_EN
#(
  parameter int unsigned HOLD_MAX = 16
)
`endif
(
  input logic             iClk,
  input logic             iRst_n,
  rr_bus_arbiter_if.slave bus
);
  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] w_search;
  logic             w_any;
  logic             w_owner_req;

  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_nxt;
  logic             r_busy, w_busy_nxt;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned      CNT_W     = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_timeout;
  logic             w_revoke;
  logic             w_expire;

  assign w_expire = (r_cnt == HOLD_LAST);
`endif

  assign w_any       = |bus.iReq;
  assign w_owner_req = bus.iReq[r_owner];

  // First requester after ptr; iterating downward lets the nearest one win, i=8 is ptr itself.
  always_comb begin
    w_search = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (bus.iReq[r_ptr + IDX_W'(i)]) begin
        w_search = r_ptr + IDX_W'(i);
      end
    end
  end

  // State register plus registered outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state   <= S_IDLE;
      r_owner   <= '0;
      r_ptr     <= IDX_W'(N_REQ - 1);
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_busy    <= w_busy_nxt;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_revoke;
`endif
    end
  end

  // Next state; ptr moves only when a BUSY grant ends so the old owner ranks last.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
`ifdef ARB_TIMEOUT_EN
    w_revoke    = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_TURN: begin
        if (w_any) begin
          w_state_nxt = S_BUSY;
          w_owner_nxt = w_search;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (!w_owner_req) begin
          w_state_nxt = S_TURN;
          w_ptr_nxt   = r_owner;
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_expire) begin
          w_state_nxt = S_TURN;
          w_ptr_nxt   = r_owner;
          w_revoke    = 1'b1;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from next state and owner.
  always_comb begin
    w_busy_nxt    = (w_state_nxt == S_BUSY);
    w_gnt_idx_nxt = '0;
    w_gnt_nxt     = '0;
    if (w_busy_nxt) begin
      w_gnt_idx_nxt = w_owner_nxt;
      w_gnt_nxt     = N_REQ'(1) << w_owner_nxt;
    end
`ifdef ARB_TIMEOUT_EN
    w_cnt_nxt = (r_state == S_BUSY) ? r_cnt + CNT_W'(1) : '0;
`endif
  end

  assign bus.oGnt    = r_gnt;
  assign bus.oGntIdx = r_gnt_idx;
  assign bus.oBusy   = r_busy;
`ifdef ARB_TIMEOUT_EN
  assign bus.oTimeout = r_timeout;
`else
  assign bus.oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed self-checking bench for rr_bus_arbiter; timeout section follows ARB_TIMEOUT_EN.
module tb_rr_bus_arbiter;
  logic iClk;
  logic iRst_n;
  int   checks;
  int   errors;

  rr_bus_arbiter_if bus ();

`ifdef ARB_TIMEOUT_EN
  rr_bus_arbiter #(.HOLD_MAX(4)) u_dut (.iClk(iClk), .iRst_n(iRst_n), .bus(bus));
`else
  rr_bus_arbiter u_dut (.iClk(iClk), .iRst_n(iRst_n), .bus(bus));
`endif

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_owner(input string tag, input int idx);
    chk({tag, "_idx"},  32'(bus.oGntIdx), 32'(idx));
    chk({tag, "_gnt"},  32'(bus.oGnt),    32'(8'(1) << idx));
    chk({tag, "_busy"}, 32'(bus.oBusy),   32'h1);
  endtask

  task automatic chk_free(input string tag);
    chk({tag, "_gnt"},  32'(bus.oGnt),    32'h0);
    chk({tag, "_idx"},  32'(bus.oGntIdx), 32'h0);
    chk({tag, "_busy"}, 32'(bus.oBusy),   32'h0);
  endtask

  task automatic do_reset();
    bus.iReq = 8'h00;
    iRst_n   = 1'b0;
    tick();
    iRst_n   = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    bus.iReq = 8'h00;
    iRst_n   = 1'b0;

    // Reset state
    tick();
    tick();
    chk_free("reset");
    chk("reset_tmo", 32'(bus.oTimeout), 32'h0);
    iRst_n = 1'b1;

    // Single requester: one-cycle latency, then TURN, then IDLE
    bus.iReq = 8'h01;
    tick();
    chk_owner("single", 0);
    bus.iReq = 8'h00;
    tick();
    chk_free("single_turn");
    tick();
    chk_free("single_idle");

    // Round robin from a fresh pointer: 0..7 then 0
    do_reset();
    bus.iReq = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_owner("rr_first", k % 8);
      tick();
      tick();
      chk_owner("rr_held", k % 8);
      if (k < 8) begin
        bus.iReq = 8'hFF & ~(8'(1) << (k % 8));
        tick();
        chk_free("rr_turn");
        bus.iReq = 8'hFF;
      end
    end

    // No preemption: owner 3 holds against all other requests
    bus.iReq = 8'h08;
    tick();
    chk_free("np_turn");
    tick();
    chk_owner("np_grant", 3);
    bus.iReq = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("np_hold_gnt", 32'(bus.oGnt), 32'h08);
    end
    bus.iReq = 8'hF7;
    tick();
    chk_free("np_release");
    tick();
    chk_owner("np_next", 4);

    // Wrap and skip from ptr=6 with iReq=05
    bus.iReq = 8'h40;
    tick();
    tick();
    chk_owner("wrap_six", 6);
    bus.iReq = 8'h05;
    tick();
    chk_free("wrap_turn");
    tick();
    chk_owner("wrap_zero", 0);
    bus.iReq = 8'h04;
    tick();
    bus.iReq = 8'h05;
    tick();
    chk_owner("wrap_two", 2);
    bus.iReq = 8'h01;
    tick();
    bus.iReq = 8'h05;
    tick();
    chk_owner("wrap_zero_again", 0);

    // Same owner re-granted when it re-asserts alone during TURN
    bus.iReq = 8'h00;
    tick();
    chk_free("same_turn");
    bus.iReq = 8'h01;
    tick();
    chk_owner("same_regrant", 0);
    bus.iReq = 8'h00;
    tick();
    tick();
    chk_free("same_idle");

    // Hold limit
    do_reset();
    bus.iReq = 8'h03;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_owner("tmo_own0", 0);
      chk("tmo_own0_pulse", 32'(bus.oTimeout), 32'h0);
    end
    tick();
    chk_free("tmo_turn0");
    chk("tmo_pulse0", 32'(bus.oTimeout), 32'h1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_owner("tmo_own1", 1);
      chk("tmo_own1_pulse", 32'(bus.oTimeout), 32'h0);
    end
    tick();
    chk_free("tmo_turn1");
    chk("tmo_pulse1", 32'(bus.oTimeout), 32'h1);
    tick();
    chk_owner("tmo_back0", 0);
    chk("tmo_back0_pulse", 32'(bus.oTimeout), 32'h0);
`else
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("hold_gnt", 32'(bus.oGnt), 32'h01);
      chk("hold_tmo", 32'(bus.oTimeout), 32'h0);
    end
`endif

    // Asynchronous reset in the middle of a grant
    do_reset();
    bus.iReq = 8'h04;
    tick();
    chk_owner("mid_pre", 2);
    #2;
    iRst_n = 1'b0;
    #1;
    chk_free("mid_async");
    chk("mid_async_tmo", 32'(bus.oTimeout), 32'h0);
    #2;
    iRst_n = 1'b1;
    tick();
    tick();
    chk_owner("mid_regrant", 2);

    bus.iReq = 8'h00;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares the 16-bit CPU internal bus between 8 requesters (e.g. ALU, register file, memory interface, I/O).
- Holds one owner at a time; ownership lasts while the owner keeps its request high.
- Produces a 3-bit owner index, plus a one-hot grant vector equal to the 3-to-8 decode of that index.
- Inserts a one-cycle bus turnaround between owners.

Parameters:
- HOLD_MAX, 16, maximum consecutive BUSY cycles per grant. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- iClk  input  1  system clock, rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iReq  input  8  request lines; bit k = requester k.
- oGnt  output  8  one-hot grant; all zero when no owner.
- oGntIdx  output  3  index of current owner; 0 when no owner.
- oBusy  output  1  1 while an owner holds the bus.
- oTimeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- All outputs are registered; there is no combinational path from iReq to any output.
- Reset (iRst_n=0, asynchronous, at any time including mid-grant):
  - state=IDLE; oGnt=8'h00, oGntIdx=0, oBusy=0, oTimeout=0.
  - Last-owner pointer ptr=7, so the first search starts at requester 0.
  - Hold counter=0.
- Search function: the first set bit of iReq scanning ptr+1, ptr+2, ..., ptr+8, modulo 8 (wraps 7→0).
- States:
  - IDLE: no owner, outputs zero.
    - iReq != 0 sampled at edge N → BUSY at edge N. Owner = search result; oGnt/oGntIdx/oBusy valid from N+1.
    - Grant latency = 1 cycle from request sampled to grant visible.
    - iReq == 0 → stay IDLE.
  - BUSY: owner = oGntIdx.
    - Stay while iReq[owner]=1. Requests from other requesters are ignored; no preemption.
    - iReq[owner]=0 → TURN; ptr←owner.
  - TURN: exactly one cycle with oGnt=0, oBusy=0, oGntIdx=0 (bus turnaround). Then:
    - iReq != 0 → BUSY with the search result from ptr, sampled in the TURN cycle.
    - Otherwise → IDLE.
- Fairness:
  - The previous owner has the lowest priority in the next search.
  - With all 8 requesting continuously and each dropping after its grant, the grant order is 0,1,...,7,0.
- Same owner twice: if the owner drops and re-asserts during TURN, and no other requester is active, it is granted again after TURN.
- A request bit that pulses only while another requester owns the bus is lost. Requesters must hold iReq until granted.
- oGnt always equals the one-hot decode of oGntIdx when oBusy=1, and is 0 otherwise.
- Pointer update happens only on a BUSY→TURN exit.
- Pointer arithmetic is 3-bit and wraps naturally.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to BUSY and increments each BUSY cycle.
  - If the counter reaches HOLD_MAX-1 while iReq[owner] is still 1: → TURN, ptr←owner, and oTimeout=1 for the single TURN cycle.
  - The revoked requester is eligible again only after all other active requesters have been served in rotation.
  - A normal release on the same cycle as the timeout counts as a normal release; oTimeout stays 0.
- Undefined:
  - No hold counter is built; oTimeout is tied to 0 and a grant may be held indefinitely.
  - The HOLD_MAX parameter is ignored.

Test Plan:
- Reset mid-grant:
  - Hold iReq=8'h04 until oGnt=8'h04.
  - Pulse iRst_n low for 3 ns, off-edge → outputs 0 immediately.
  - After release with iReq=8'h04 still high: oGnt=8'h04 on the 2nd edge; ptr restarted at 7.
- Single requester latency: iReq=8'h01 from cycle 0 → oGnt=8'h01, oGntIdx=0, oBusy=1 at cycle 1. Drop iReq → cycle N+1 TURN (oGnt=0), then IDLE.
- Round-robin:
  - iReq=8'hFF; each owner drops its bit for one cycle after 3 BUSY cycles, then re-raises it.
  - Required: oGntIdx sequence 0,1,2,3,4,5,6,7,0, with one zero-grant TURN cycle between each.
- Wrap and skip: ptr=6 (after owner 6 releases), iReq=8'h05 → next owner 0, then 2, then 0.
- No preemption: owner 3 holds for 10 cycles while iReq=8'hFF → oGnt stays 8'h08 for all 10 cycles.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4):
  - iReq=8'h03 held.
  - Required: owner 0 for 4 cycles, then TURN with oTimeout=1, then owner 1 for 4 cycles, then oTimeout again, then owner 0.
  - Without the macro: owner 0 holds indefinitely and oTimeout stays 0.
